lane_renderer: RTL and testbench
================================

Name: lane_renderer

Overview:
Parametrised multi-lane playfield renderer for the VGA rhythm-game display. It generalises the single fixed white stripe into NUM_LANES equal-pitch lanes and adds three things: a per-lane "hit flash" driven by player buttons and timed in frames, a vertically scrolling dash pattern, and a registered pixel output. It sits between the VGA timing generator (col/row/valid/frame_start) and the top-level colour mux.

Parameters:
NUM_LANES, 4, number of lanes (1..6)
LANE_X0, 110, column of the left edge of lane 0
LANE_PITCH, 105, column distance between left edges of adjacent lanes
LANE_WIDTH, 100, lane width in columns (LANE_WIDTH <= LANE_PITCH)
DASH_LOG2, 5, dash period = 2**DASH_LOG2 rows; lit half = first 2**(DASH_LOG2-1) rows
SCROLL_STEP, 2, rows the dash pattern advances per frame
FLASH_FRAMES, 8, frames a lane stays flashed after a press (1..255)
LANE_RGB, 6'b111111, lit dash colour
DIM_RGB, 6'b010101, unlit dash colour inside a lane
FLASH_RGB, 6'b111100, colour of a flashing lane

Ports:
clk  input  1  pixel clock
rst  input  1  asynchronous active-high reset
col  input  10  current pixel column
row  input  10  current pixel row
valid  input  1  high inside the visible area
frame_start  input  1  one-cycle pulse, once per frame
scroll_en  input  1  enables dash scrolling
press  input  NUM_LANES  raw asynchronous button levels, bit k = lane k
lane_rgb  output  6  registered pixel colour
lane_hit  output  NUM_LANES  registered one-hot lane membership of the pixel (0 if none or !valid)

Behaviour:
- Reset (async, active-high): lane_rgb=0, lane_hit=0, scroll offset=0, all flash counters=0, press sync and edge registers=0.
- Lane k contains the pixel iff (LANE_X0 + k*LANE_PITCH) < col < (LANE_X0 + k*LANE_PITCH + LANE_WIDTH), with strict bounds at both edges. Compare in 11-bit arithmetic so that the sums do not overflow. Lanes never overlap.
- Scroll offset: DASH_LOG2-bit register. On a frame_start cycle with scroll_en=1: offset <= offset + SCROLL_STEP, which wraps modulo 2**DASH_LOG2. Otherwise the offset holds.
- Dash lit iff bit (DASH_LOG2-1) of (row + offset), truncated to DASH_LOG2 bits, is 0.
- Press path:
  - Each press bit passes through a 2-flop synchroniser, then a rising-edge detector.
  - An edge on lane k loads flash_cnt[k] = FLASH_FRAMES (8 bits).
  - On frame_start, every nonzero counter decrements by 1.
  - Edge and frame_start in the same cycle: the load wins and there is no decrement.
  - Holding the button does not retrigger. A new edge while the counter is nonzero reloads it to FLASH_FRAMES.
  - A lane flashes while flash_cnt[k] != 0.
- Colour priority, evaluated combinationally and registered at the next clk edge:
  1. !valid -> 0
  2. pixel in flashing lane -> FLASH_RGB
  3. pixel in lane, dash lit -> LANE_RGB
  4. pixel in lane, dash unlit -> DIM_RGB
  5. otherwise -> 0
- lane_hit has the same 1-cycle registration as lane_rgb.
- Latency:
  - lane_rgb/lane_hit reflect the col/row/valid sampled on the previous edge, using the flash and offset state before that edge.
  - A press edge reaches the output 4 clocks after the press bit rises: 2 sync flops, the edge register, then the output register.
- Reset mid-frame clears everything immediately. Output stays 0 until the first post-reset edge with valid=1.

Test Plan:
- Reset: assert rst with valid=1, col=200 -> lane_rgb=0, lane_hit=0 while reset is held. After release with row=0, col=200, offset=0 -> next cycle lane_rgb=6'b111111, lane_hit=4'b0001.
- Boundaries (defaults): col=110 -> 0; col=111 -> lane 0; col=209 -> lane 0; col=210 -> 0; col=215 -> 0; col=216 -> lane 1; col=525 -> 0; valid=0 at col=200 -> 0.
- Dash and scroll:
  - offset 0, row=15 -> LANE_RGB; row=16 -> DIM_RGB.
  - After 8 frame_start pulses with scroll_en=1, offset=16: row=0 -> DIM_RGB.
  - After 16 pulses the offset wraps to 0.
  - scroll_en=0 -> offset holds.
- Flash:
  - press[2] rises -> within 4 clocks col=350 reads 6'b111100.
  - After exactly 8 frame_start pulses it reads LANE_RGB/DIM_RGB again.
  - Holding press for 20 frames still ends the flash after 8 frames.
- Simultaneous events:
  - Edge on the same cycle as frame_start -> counter=8, not 7.
  - Re-press at counter=3 -> reload to 8.
  - Presses on lanes 0 and 3 together -> both flash independently.
- Reset mid-flash: rst asserted when counter=5 -> output drops to 0 asynchronously; after release the lane shows the normal dash colour and no flash.

Source files
------------

// File: rtl/lane_renderer.sv
// lane_renderer: multi-lane playfield renderer for the VGA rhythm-game display.
// Produces a registered 6-bit colour and one-hot lane membership per pixel,
// with per-lane hit flashes (timed in frames) and a vertically scrolling dash.
module lane_renderer #(
  parameter int          NUM_LANES    = 4,
  parameter int          LANE_X0      = 110,
  parameter int          LANE_PITCH   = 105,
  parameter int          LANE_WIDTH   = 100,
  parameter int          DASH_LOG2    = 5,
  parameter int          SCROLL_STEP  = 2,
  parameter int          FLASH_FRAMES = 8,
  parameter logic [5:0]  LANE_RGB     = 6'b111111,
  parameter logic [5:0]  DIM_RGB      = 6'b010101,
  parameter logic [5:0]  FLASH_RGB    = 6'b111100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           col,
  input  logic [9:0]           row,
  input  logic                 valid,
  input  logic                 frame_start,
  input  logic                 scroll_en,
  input  logic [NUM_LANES-1:0] press,
  output logic [5:0]           lane_rgb,
  output logic [NUM_LANES-1:0] lane_hit
);

  logic [DASH_LOG2-1:0] offset;
  logic [DASH_LOG2-1:0] dash_pos;
  logic                 dash_lit;
  logic [NUM_LANES-1:0] press_s1, press_s2, press_s3;
  logic [NUM_LANES-1:0] press_edge;
  logic [NUM_LANES-1:0] in_lane;
  logic [NUM_LANES-1:0] flashing;
  logic [7:0]           flash_cnt [NUM_LANES];
  logic [5:0]           rgb_next;

  // Rising edge seen one flop after the two-stage synchroniser.
  assign press_edge = press_s2 & ~press_s3;

  // Dash phase only depends on the low DASH_LOG2 bits of row + offset.
  assign dash_pos = row[DASH_LOG2-1:0] + offset;
  assign dash_lit = ~dash_pos[DASH_LOG2-1];

  // Button synchroniser and edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_s1 <= '0;
      press_s2 <= '0;
      press_s3 <= '0;
    end else begin
      press_s1 <= press;
      press_s2 <= press_s1;
      press_s3 <= press_s2;
    end
  end

  // Scroll offset advances once per frame when enabled, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset <= '0;
    end else if (frame_start && scroll_en) begin
      offset <= offset + DASH_LOG2'(SCROLL_STEP);
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    // Bounds widened to 11 bits so the right edge sum cannot overflow.
    localparam logic [10:0] LO = 11'(LANE_X0 + k * LANE_PITCH);
    localparam logic [10:0] HI = 11'(LANE_X0 + k * LANE_PITCH + LANE_WIDTH);

    assign in_lane[k]  = ({1'b0, col} > LO) && ({1'b0, col} < HI);
    assign flashing[k] = (flash_cnt[k] != 8'd0);

    // Flash down-counter: a press edge reloads and beats a same-cycle frame tick.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        flash_cnt[k] <= 8'd0;
      end else if (press_edge[k]) begin
        flash_cnt[k] <= 8'(FLASH_FRAMES);
      end else if (frame_start && flashing[k]) begin
        flash_cnt[k] <= flash_cnt[k] - 8'd1;
      end
    end
  end

  // Colour priority: blanking, flash, lit dash, dim dash, background.
  always_comb begin
    rgb_next = 6'd0;
    if (valid) begin
      if (|(in_lane & flashing)) begin
        rgb_next = FLASH_RGB;
      end else if (|in_lane) begin
        rgb_next = dash_lit ? LANE_RGB : DIM_RGB;
      end
    end
  end

  // Output register for colour and lane membership.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_rgb <= 6'd0;
      lane_hit <= '0;
    end else begin
      lane_rgb <= rgb_next;
      lane_hit <= valid ? in_lane : '0;
    end
  end

endmodule

// File: tb/tb_lane_renderer.sv
// tb_lane_renderer: directed and randomized checks of lane_renderer against a
// behavioural model of lanes, dash phase, scroll offset and flash timers.
module tb_lane_renderer;

  localparam int NL = 4;
  localparam logic [5:0] C_LANE  = 6'b111111;
  localparam logic [5:0] C_DIM   = 6'b010101;
  localparam logic [5:0] C_FLASH = 6'b111100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [9:0]    col = '0;
  logic [9:0]    row = '0;
  logic          valid = 1'b0;
  logic          frame_start = 1'b0;
  logic          scroll_en = 1'b0;
  logic [NL-1:0] press = '0;
  logic [5:0]    lane_rgb;
  logic [NL-1:0] lane_hit;

  lane_renderer dut (
    .clk         (clk),
    .rst         (rst),
    .col         (col),
    .row         (row),
    .valid       (valid),
    .frame_start (frame_start),
    .scroll_en   (scroll_en),
    .press       (press),
    .lane_rgb    (lane_rgb),
    .lane_hit    (lane_hit)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int            m_off;
  int            m_cnt [NL];
  logic [NL-1:0] m_samp [3];   // press as sampled 1, 2, 3 edges ago
  logic [5:0]    exp_rgb;
  logic [NL-1:0] exp_hit;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_clear();
    m_off = 0;
    for (int k = 0; k < NL; k++) m_cnt[k] = 0;
    for (int i = 0; i < 3; i++) m_samp[i] = '0;
    exp_rgb = '0;
    exp_hit = '0;
  endtask

  // One clock edge of the reference: output from pre-edge state, then update.
  task automatic model_edge();
    int c, r, lane;
    logic [NL-1:0] rise;
    c = int'(col);
    r = int'(row);
    lane = -1;
    exp_rgb = '0;
    exp_hit = '0;
    if (valid) begin
      for (int k = 0; k < NL; k++)
        if (c > 110 + k * 105 && c < 110 + k * 105 + 100) begin
          exp_hit[k] = 1'b1;
          lane = k;
        end
      if (lane >= 0) begin
        if (m_cnt[lane] > 0)               exp_rgb = C_FLASH;
        else if (((r + m_off) % 32) < 16) exp_rgb = C_LANE;
        else                              exp_rgb = C_DIM;
      end
    end
    // A button press becomes visible to the timers two samples after it was seen.
    rise = m_samp[1] & ~m_samp[2];
    for (int k = 0; k < NL; k++) begin
      if (rise[k])                         m_cnt[k] = 8;
      else if (frame_start && m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
    end
    if (frame_start && scroll_en) m_off = (m_off + 2) % 32;
    m_samp[2] = m_samp[1];
    m_samp[1] = m_samp[0];
    m_samp[0] = press;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("rgb", {2'b0, lane_rgb}, {2'b0, exp_rgb});
    check("hit", {4'b0, lane_hit}, {4'b0, exp_hit});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Asserted just after a negedge; outputs must clear without a clock edge.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_rgb", {2'b0, lane_rgb}, 8'h00);
    check("rst_hit", {4'b0, lane_hit}, 8'h00);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check("rst_hold", {2'b0, lane_rgb}, 8'h00);
    rst = 1'b0;
  endtask

  // Expect the sampled pixel to flash for exactly 8 more frames.
  task automatic flash_countdown(input string tag);
    for (int i = 0; i < 8; i++) begin
      frame();
      step();
      check(tag, {7'b0, lane_rgb == C_FLASH}, {7'b0, i < 7});
    end
  endtask

  int bcol [8] = '{110, 111, 209, 210, 215, 216, 525, 200};
  logic [3:0] bhit [8] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0};

  initial begin
    model_clear();
    @(negedge clk);
    valid = 1'b1;
    col = 10'd200;
    row = 10'd0;
    apply_reset();
    step();
    check("post_rst_rgb", {2'b0, lane_rgb}, {2'b0, C_LANE});
    check("post_rst_hit", {4'b0, lane_hit}, 8'h01);

    for (int i = 0; i < 8; i++) begin
      col = 10'(bcol[i]);
      valid = (i != 7);
      step();
      check("bound_hit", {4'b0, lane_hit}, {4'b0, bhit[i]});
    end
    valid = 1'b1;
    col = 10'd200;

    row = 10'd15; step(); check("dash_15", {2'b0, lane_rgb}, {2'b0, C_LANE});
    row = 10'd16; step(); check("dash_16", {2'b0, lane_rgb}, {2'b0, C_DIM});
    row = 10'd0;
    scroll_en = 1'b1;
    for (int i = 0; i < 8; i++) frame();
    step(); check("scroll_16", {2'b0, lane_rgb}, {2'b0, C_DIM});
    for (int i = 0; i < 8; i++) frame();
    step(); check("scroll_wrap", {2'b0, lane_rgb}, {2'b0, C_LANE});
    scroll_en = 1'b0;
    for (int i = 0; i < 5; i++) frame();
    step(); check("scroll_hold", {2'b0, lane_rgb}, {2'b0, C_LANE});

    // Flash on lane 2, held for 20 frames
    col = 10'd350;
    press = 4'b0100;
    steps(3);
    check("flash_lat3", {7'b0, lane_rgb == C_FLASH}, 8'h00);
    step();
    check("flash_lat4", {2'b0, lane_rgb}, {2'b0, C_FLASH});
    flash_countdown("flash_run");
    for (int i = 0; i < 12; i++) frame();
    step();
    check("flash_held", {7'b0, lane_rgb == C_FLASH}, 8'h00);

    // Edge coincides with frame_start: full 8 frames remain
    press = '0;
    steps(3);
    press = 4'b0100;
    steps(2);
    frame();
    step();
    check("coinc_on", {2'b0, lane_rgb}, {2'b0, C_FLASH});
    flash_countdown("coinc_run");

    // Re-press at counter 3 reloads to 8
    press = '0;
    steps(3);
    press = 4'b0100;
    steps(4);
    for (int i = 0; i < 5; i++) frame();
    press = '0;
    steps(3);
    press = 4'b0100;
    steps(3);
    flash_countdown("repress_run");

    // Lanes 0 and 3 together
    press = '0;
    steps(3);
    press = 4'b1001;
    steps(4);
    col = 10'd150; step(); check("dual_l0", {2'b0, lane_rgb}, {2'b0, C_FLASH});
    col = 10'd450; step(); check("dual_l3", {2'b0, lane_rgb}, {2'b0, C_FLASH});
    col = 10'd350; step(); check("dual_l2", {7'b0, lane_rgb == C_FLASH}, 8'h00);

    // Reset with lane 1 at counter 5
    press = '0;
    steps(3);
    col = 10'd250;
    press = 4'b0010;
    steps(4);
    for (int i = 0; i < 3; i++) frame();
    check("pre_rst_flash", {2'b0, lane_rgb}, {2'b0, C_FLASH});
    press = '0;
    apply_reset();
    steps(2);
    check("after_rst_noflash", {7'b0, lane_rgb == C_FLASH}, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        col = 10'($urandom_range(105, 530));
      else
        col = 10'($urandom_range(0, 639));
      row = 10'($urandom_range(0, 479));
      valid = ($urandom_range(0, 7) != 0);
      frame_start = ($urandom_range(0, 15) == 0);
      scroll_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) press = NL'($urandom);
      step();
    end
    frame_start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
